// File: rtl/wb_model_pkg.sv
// Shared types and constants for the Wishbone RAM responder model.
//   wait_mode_t  : how the wait for one access is chosen
//   resp_state_t : responder FSM states
//   LFSR_TAPS    : Galois feedback mask for x^16+x^14+x^13+x^11+1
package wb_model_pkg;

  typedef enum logic [1:0] {
    FIXED_MIN = 2'd0,
    FIXED_MAX = 2'd1,
    RANDOM    = 2'd2,
    EXTERNAL  = 2'd3
  } wait_mode_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } resp_state_t;

  // Right-shifting Galois form: bit 0 is the output and, when it is set,
  // this mask is folded into the shifted state.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/wb_ram_responder_if.sv
// Wishbone classic bus bundle between a CPU master and the RAM responder.
//   adr   : word address          cyc/stb/we : classic cycle controls
//   sel   : byte lanes            dat_w      : write data
//   dat_r : read data (with ack)  ack        : one-cycle acknowledge
interface wb_ram_responder_if;
  logic [29:0] adr;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] dat_w;
  logic [31:0] dat_r;
  logic        ack;

  modport master (output adr, cyc, stb, we, sel, dat_w, input dat_r, ack);
  modport slave  (input adr, cyc, stb, we, sel, dat_w, output dat_r, ack);
endinterface

// File: rtl/wb_lfsr16.sv
// Free-running 16-bit Galois LFSR used to draw random wait states.
//   clk   : clock
//   rst   : synchronous active-high reset, loads SEED
//   state : current LFSR value
module wb_lfsr16
  import wb_model_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] state
);

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register samples the values from before the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SEED;
    end else begin
      state <= {1'b0, state[15:1]} ^ (state[0] ? LFSR_TAPS : 16'h0000);
    end
  end

endmodule

// File: rtl/wb_ram_responder.sv
// Wishbone classic target backed by a word-addressed RAM with byte-lane
// writes and selectable wait states.
//   clk, rst     : clock, synchronous active-high reset
//   bus          : Wishbone slave port (adr/cyc/stb/we/sel/dat_w in, dat_r/ack out)
//   wait_mode    : 0 fixed MIN_WAIT, 1 fixed MAX_WAIT, 2 LFSR random, 3 external
//   wait_req     : external stall request (mode 3)
//   abort        : one-cycle pulse when the master gives up during WAIT
//   timeout      : sticky, set when mode 3 is forced to ack by the watchdog
//   access_count : completed accesses, wraps
module wb_ram_responder
  import wb_model_pkg::*;
#(
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned MIN_WAIT  = 1,
  parameter int unsigned MAX_WAIT  = 8,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                  clk,
  input  logic                  rst,
  wb_ram_responder_if.slave     bus,
  input  logic [1:0]            wait_mode,
  input  logic                  wait_req,
  output logic                  abort,
  output logic                  timeout,
  output logic [31:0]           access_count
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned SPAN = MAX_WAIT - MIN_WAIT + 1;
  // Wide enough to hold MAX_WAIT plus the post-increment in WAIT.
  localparam int unsigned CW   = $clog2(MAX_WAIT + 2);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("wb_ram_responder: DEPTH must be a power of two >= 2");
  end
  if (MIN_WAIT < 1 || MAX_WAIT < MIN_WAIT) begin : g_bad_wait
    $error("wb_ram_responder: need 1 <= MIN_WAIT <= MAX_WAIT");
  end
  if ((SPAN & (SPAN - 1)) != 0) begin : g_bad_span
    $error("wb_ram_responder: MAX_WAIT-MIN_WAIT+1 must be a power of two");
  end
  if (LFSR_SEED == 16'h0000) begin : g_bad_seed
    $error("wb_ram_responder: LFSR_SEED must be nonzero");
  end

  resp_state_t   state;
  wait_mode_t    mode_in;
  wait_mode_t    mode_q;
  logic [15:0]   lfsr;
  logic [CW-1:0] wait_sel;
  logic [CW-1:0] wcnt;      // edges still owed before the earliest ack
  logic [CW-1:0] lat;       // latency the access would get if acked on this edge
  logic [AW-1:0] idx_q;
  logic          we_q;
  logic [3:0]    sel_q;
  logic [31:0]   dat_q;

  logic          req;
  logic          go_ack;
  logic          hit_wd;
  logic [AW-1:0] cur_idx;
  logic          cur_we;
  logic [3:0]    cur_sel;
  logic [31:0]   cur_dat;
  logic          unused_adr;

  logic [31:0]   mem [DEPTH];

  wb_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .state (lfsr)
  );

  assign mode_in    = wait_mode_t'(wait_mode);
  assign req        = bus.cyc && bus.stb;
  // Upper address bits alias onto the same words.
  assign unused_adr = ^bus.adr;

  // A W=1 access goes straight from IDLE to ACK, so the access fields come
  // from the bus in IDLE and from the latched copy afterwards.
  always_comb begin
    if (state == IDLE) begin
      cur_idx = bus.adr[AW-1:0];
      cur_we  = bus.we;
      cur_sel = bus.sel;
      cur_dat = bus.dat_w;
    end else begin
      cur_idx = idx_q;
      cur_we  = we_q;
      cur_sel = sel_q;
      cur_dat = dat_q;
    end
  end

  always_comb begin
    unique case (mode_in)
      FIXED_MAX: wait_sel = CW'(MAX_WAIT);
      RANDOM:    wait_sel = CW'(MIN_WAIT) + CW'(lfsr & 16'(SPAN - 1));
      default:   wait_sel = CW'(MIN_WAIT);
    endcase
  end

  // Decide whether this edge enters ACK and whether the mode-3 watchdog fired.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    go_ack = 1'b0;
    hit_wd = 1'b0;
    unique case (state)
      IDLE: begin
        if (req && wait_sel == CW'(1)) begin
          if (mode_in == EXTERNAL && wait_req) begin
            if (MAX_WAIT == 1) begin
              go_ack = 1'b1;
              hit_wd = 1'b1;
            end
          end else begin
            go_ack = 1'b1;
          end
        end
      end
      WAIT: begin
        if (req && wcnt <= CW'(1)) begin
          if (mode_q == EXTERNAL && wait_req) begin
            if (lat == CW'(MAX_WAIT)) begin
              go_ack = 1'b1;
              hit_wd = 1'b1;
            end
          end else begin
            go_ack = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // NOTE: the memory array is deliberately left out of reset; only the
  // control state is cleared, so contents survive a reset.
  always_ff @(posedge clk) begin
    if (!rst && go_ack && cur_we) begin
      for (int b = 0; b < 4; b++) begin
        if (cur_sel[b]) mem[cur_idx][8*b +: 8] <= cur_dat[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      mode_q       <= FIXED_MIN;
      wcnt         <= '0;
      lat          <= '0;
      idx_q        <= '0;
      we_q         <= 1'b0;
      sel_q        <= '0;
      dat_q        <= '0;
      bus.ack      <= 1'b0;
      bus.dat_r    <= '0;
      abort        <= 1'b0;
      timeout      <= 1'b0;
      access_count <= '0;
    end else begin
      bus.ack   <= go_ack;
      bus.dat_r <= '0;
      abort     <= 1'b0;
      if (go_ack) begin
        access_count <= access_count + 32'd1;
        timeout      <= timeout | hit_wd;
        if (!cur_we) bus.dat_r <= mem[cur_idx];
      end

      unique case (state)
        IDLE: begin
          if (req) begin
            idx_q  <= bus.adr[AW-1:0];
            we_q   <= bus.we;
            sel_q  <= bus.sel;
            dat_q  <= bus.dat_w;
            mode_q <= mode_in;
            wcnt   <= wait_sel - CW'(1);
            lat    <= CW'(2);
            state  <= go_ack ? ACK : WAIT;
          end
        end
        WAIT: begin
          if (!req) begin
            abort <= 1'b1;
            state <= IDLE;
          end else if (go_ack) begin
            state <= ACK;
          end else begin
            if (wcnt > CW'(1)) wcnt <= wcnt - CW'(1);
            lat <= lat + CW'(1);
          end
        end
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_ram_responder.sv
// Directed self-checking bench for wb_ram_responder (default parameters:
// DEPTH=1024, MIN_WAIT=1, MAX_WAIT=8).
module tb_wb_ram_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  wait_mode;
  logic        wait_req;
  logic        abort;
  logic        timeout;
  logic [31:0] access_count;

  wb_ram_responder_if bus();

  wb_ram_responder dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .wait_mode    (wait_mode),
    .wait_req     (wait_req),
    .abort        (abort),
    .timeout      (timeout),
    .access_count (access_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int early_ack  = 0;   // ack seen in a request's first cycle
  int stray_data = 0;   // dat_r nonzero while ack low
  logic [31:0] exp_count = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
    end
  endtask

  // One access starting at a negedge. lat=0 means no ack within the budget.
  // wreq_drop: negedge index at which wait_req is released (0 = never).
  task automatic xfer(input logic we_i, input logic [29:0] a, input logic [3:0] s,
                      input logic [31:0] d, input int wreq_drop,
                      output int lat, output logic [31:0] rd);
    bus.adr = a; bus.we = we_i; bus.sel = s; bus.dat_w = d;
    bus.cyc = 1'b1; bus.stb = 1'b1;
    lat = 0; rd = '0;
    #1;
    if (bus.ack) early_ack++;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      @(negedge clk);
      if (bus.ack) begin
        lat = k;
        rd  = bus.dat_r;
        exp_count++;
      end else begin
        if (bus.dat_r != 32'h0) stray_data++;
        if (k == wreq_drop) wait_req = 1'b0;
      end
    end
    bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0;
    @(negedge clk);
    if (bus.dat_r != 32'h0) stray_data++;
  endtask

  initial begin
    int lat;
    logic [31:0] rd;
    int n_ack, n_abort, abort_at, lo_bad, distinct;
    logic [15:0] seen;

    rst = 1'b1; wait_mode = 2'd0; wait_req = 1'b0;
    bus.adr = '0; bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0;
    bus.sel = '0; bus.dat_w = '0;
    repeat (3) @(negedge clk);
    check("rst_ack",   {31'b0, bus.ack}, 32'd0);
    check("rst_dat_r", bus.dat_r, 32'd0);
    check("rst_abort", {31'b0, abort}, 32'd0);
    check("rst_tmo",   {31'b0, timeout}, 32'd0);
    check("rst_count", access_count, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Mode 0: write then read, one-cycle latency each.
    wait_mode = 2'd0;
    xfer(1'b1, 30'd5, 4'hF, 32'hDEADBEEF, 0, lat, rd);
    check("m0_wr_lat", lat, 32'd1);
    check("m0_wr_dat_r", rd, 32'd0);
    xfer(1'b0, 30'd5, 4'h0, 32'h0, 0, lat, rd);
    check("m0_rd_lat", lat, 32'd1);
    check("m0_rd_data", rd, 32'hDEADBEEF);
    check("m0_count", access_count, 32'd2);
    // Aliased upper address bits hit the same word.
    xfer(1'b0, 30'h2000_0005, 4'h0, 32'h0, 0, lat, rd);
    check("m0_alias", rd, 32'hDEADBEEF);

    // Mode 1: single-lane write over a preloaded word.
    xfer(1'b1, 30'd7, 4'hF, 32'h11223344, 0, lat, rd);
    wait_mode = 2'd1;
    xfer(1'b1, 30'd7, 4'b0010, 32'h0000AB00, 0, lat, rd);
    check("m1_wr_lat", lat, 32'd8);
    xfer(1'b0, 30'd7, 4'h0, 32'h0, 0, lat, rd);
    check("m1_rd_lat", lat, 32'd8);
    check("m1_rd_data", rd, 32'h1122AB44);
    check("m1_count", access_count, exp_count);

    // Mode 2: random latencies stay in range and vary.
    wait_mode = 2'd2;
    seen = '0; lo_bad = 0;
    for (int i = 0; i < 256; i++) begin
      xfer(1'b0, 30'(i), 4'h0, 32'h0, 0, lat, rd);
      if (lat < 1 || lat > 8) lo_bad++;
      else seen[lat] = 1'b1;
    end
    distinct = $countones(seen);
    check("m2_out_of_range", lo_bad, 32'd0);
    check("m2_distinct_ge4", {31'b0, distinct >= 4}, 32'd1);
    check("m2_early_ack", early_ack, 32'd0);
    check("m2_count", access_count, exp_count);

    // Mode 3: stall held past the watchdog, then a released stall.
    wait_mode = 2'd3;
    wait_req = 1'b1;
    xfer(1'b0, 30'd5, 4'h0, 32'h0, 0, lat, rd);
    wait_req = 1'b0;
    check("m3_wd_lat", lat, 32'd8);
    check("m3_wd_data", rd, 32'hDEADBEEF);
    check("m3_timeout_set", {31'b0, timeout}, 32'd1);
    wait_req = 1'b1;
    xfer(1'b0, 30'd7, 4'h0, 32'h0, 3, lat, rd);
    check("m3_rel_lat", lat, 32'd4);
    check("m3_timeout_sticky", {31'b0, timeout}, 32'd1);

    // Mode 1 abort: drop stb three cycles into WAIT of a write.
    wait_mode = 2'd1;
    bus.adr = 30'd7; bus.we = 1'b1; bus.sel = 4'hF; bus.dat_w = 32'hFFFFFFFF;
    bus.cyc = 1'b1; bus.stb = 1'b1;
    n_ack = 0; n_abort = 0; abort_at = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (bus.ack) n_ack++;
      if (abort) begin
        n_abort++;
        abort_at = k;
      end
      if (k == 3) bus.stb = 1'b0;
    end
    bus.cyc = 1'b0; bus.we = 1'b0;
    check("ab_pulses", n_abort, 32'd1);
    check("ab_when", abort_at, 32'd4);
    check("ab_no_ack", n_ack, 32'd0);
    check("ab_count", access_count, exp_count);
    wait_mode = 2'd0;
    xfer(1'b0, 30'd7, 4'h0, 32'h0, 0, lat, rd);
    check("ab_mem_kept", rd, 32'h1122AB44);

    // Reset during WAIT of a write.
    xfer(1'b1, 30'd9, 4'hF, 32'hA5A5_0909, 0, lat, rd);
    wait_mode = 2'd1;
    bus.adr = 30'd9; bus.we = 1'b1; bus.sel = 4'hF; bus.dat_w = 32'hBBBB_BBBB;
    bus.cyc = 1'b1; bus.stb = 1'b1;
    n_ack = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.ack) n_ack++;
    end
    rst = 1'b1;
    @(negedge clk);
    if (bus.ack) n_ack++;
    check("rw_no_ack", n_ack, 32'd0);
    check("rw_dat_r", bus.dat_r, 32'd0);
    check("rw_abort", {31'b0, abort}, 32'd0);
    check("rw_tmo", {31'b0, timeout}, 32'd0);
    check("rw_count", access_count, 32'd0);
    rst = 1'b0; exp_count = 0;
    bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0;
    n_abort = 0;
    repeat (2) begin
      @(negedge clk);
      if (abort || bus.ack) n_abort++;
    end
    check("rw_quiet_after", n_abort, 32'd0);
    wait_mode = 2'd0;
    xfer(1'b0, 30'd9, 4'h0, 32'h0, 0, lat, rd);
    check("rw_rd_lat", lat, 32'd1);
    check("rw_rd_data", rd, 32'hA5A5_0909);
    check("rw_rd_count", access_count, 32'd1);

    check("dat_r_idle_zero", stray_data, 32'd0);
    check("no_early_ack", early_ack, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
